// File: rtl/xps2_rx_pkg.sv
// xps2_rx_pkg: shared constants and types for the PS/2 keyboard receiver.
//   - PS/2 prefix codes (break F0, extended E0)
//   - frame FSM state encoding
//   - bus register addresses and bit positions of the STATUS/CTRL/DATA words
//   - odd-parity helper for received frames
package xps2_rx_pkg;

    localparam int DATA_W = 32;
    localparam int EVT_W  = 10;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    localparam int ST_PERR_BIT  = 0;
    localparam int ST_FERR_BIT  = 1;
    localparam int ST_OVR_BIT   = 2;
    localparam int ST_EMPTY_BIT = 3;
    localparam int ST_FULL_BIT  = 4;
    localparam int ST_COUNT_LSB = 16;
    localparam int RD_VALID_BIT = 31;

    localparam int CTRL_CLR_BIT   = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Eight data bits plus parity must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction

endpackage

// File: rtl/xps2_rx_if.sv
// xps2_rx_if: CPU data-bus select/read/write interface of the PS/2 receiver.
//   sel      peripheral select
//   we       write enable, read when 0
//   addr     0: DATA, 1: STATUS/CTRL
//   data_in  write data
//   data_out read data (registered in the peripheral)
//   irq      interrupt, high while events are buffered
interface xps2_rx_if;
    import xps2_rx_pkg::*;

    logic              sel;
    logic              we;
    logic              addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              irq;

    modport master (output sel, we, addr, data_in, input data_out, irq);
    modport slave  (input sel, we, addr, data_in, output data_out, irq);

endinterface

// File: rtl/xps2_rx_fifo.sv
// xps2_rx_fifo: synchronous FIFO for key events.
//   clk, rst   clock, synchronous active-high reset
//   flush_i    empties the FIFO (wins over push/pop)
//   push_i     write wdata_i; dropped with ovr_o pulse when full and not popping
//   pop_i      advance the read pointer (ignored when empty)
//   rdata_o    head entry; the bus logic registers it into data_out
//   full_o, empty_o, count_o   occupancy
//   ovr_o      one-cycle pulse when a push was dropped
module xps2_rx_fifo #(
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              ovr_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              pop_ok;
    logic              push_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign ovr_o   = push_i && !push_ok && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/xps2_rx.sv
// xps2_rx: PS/2 keyboard receiver peripheral.
//   clk, rst     system clock, synchronous active-high reset
//   ps2_clk_i    raw PS/2 clock (asynchronous)
//   ps2_data_i   raw PS/2 data (asynchronous)
//   bus          CPU bus slave: DATA read pops {valid, brk, ext, code},
//                STATUS read returns count/full/empty/ovr/ferr/perr,
//                CTRL write bit0 clears errors, bit1 flushes FIFO and prefixes.
//
// Frame FSM:
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data=0 on a filtered falling edge)
//   ST_DATA   | shifting 8 data bits, LSB first
//   ST_PARITY | latching the parity bit
//   ST_STOP   | checking stop bit and odd parity, delivering the byte
module xps2_rx
    import xps2_rx_pkg::*;
#(
    parameter int FIFO_ADDR_W = 3,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int BREAK_EN    = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ps2_clk_i,
    input  logic      ps2_data_i,
    xps2_rx_if.slave  bus
);

    localparam int FCNT_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    logic [1:0]        clk_sync_q;
    logic [1:0]        dat_sync_q;
    logic              filt_q;
    logic [FCNT_W-1:0] filt_cnt_q;
    logic              filt_switch;
    logic              fall;
    logic              dat_s;

    ps2_state_e        state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              byte_vld_q, byte_vld_d;
    logic              set_perr, set_ferr;

    logic [TMR_W-1:0]  tmr_q;
    logic              tmr_reload;
    logic              tmr_tc;
    logic              armed_q;

    logic              brk_q, brk_d, ext_q, ext_d;
    logic              push;
    logic              perr_q, ferr_q, ovr_q;

    logic              rd_data, rd_stat, wr_ctrl, clr_err, flush;
    logic [EVT_W-1:0]  fifo_rdata;
    logic              fifo_full, fifo_empty, fifo_ovr;
    logic [FIFO_ADDR_W:0] fifo_count;
    logic [DATA_W-1:0] data_word, stat_word, data_out_q;
    logic              irq_q;
    logic              unused_data_in;

    // Filter: the level only follows the synchronised clock after FILT_LEN equal samples.
    assign filt_switch = (clk_sync_q[1] != filt_q) && (filt_cnt_q == FCNT_W'(FILT_LEN - 1));
    assign fall        = filt_switch && filt_q;
    assign dat_s       = dat_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_switch) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FCNT_W'(1);
            end
        end
    end

    // One down-counter serves two purposes: mid-frame it is the inactivity
    // timeout; after reset it measures idle-high time so that a frame cut by
    // reset is not mistaken for a new one (armed_q gates start-bit detection).
    assign tmr_reload = fall || ((state_q == ST_IDLE) && (armed_q || !filt_q));
    assign tmr_tc     = (tmr_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q   <= TMR_LOAD;
            armed_q <= 1'b0;
        end else begin
            if (tmr_reload)   tmr_q <= TMR_LOAD;
            else if (!tmr_tc) tmr_q <= tmr_q - TMR_W'(1);
            if ((state_q == ST_IDLE) && tmr_tc) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            byte_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            byte_vld_q <= byte_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_vld_d = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        if ((state_q != ST_IDLE) && !fall && tmr_tc) begin
            state_d  = ST_IDLE;
            set_ferr = 1'b1;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !dat_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // A bad stop bit outranks a parity fault.
                    if (!dat_s)                             set_ferr   = 1'b1;
                    else if (!odd_parity_ok(shift_q, par_q)) set_perr   = 1'b1;
                    else                                    byte_vld_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Byte decode. shift_q holds until the next frame's first data bit, so it
    // is still the delivered byte one cycle after STOP.
    always_comb begin
        push  = 1'b0;
        brk_d = brk_q;
        ext_d = ext_q;
        if (flush) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (byte_vld_q) begin
            if (shift_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else begin
                push  = (BREAK_EN != 0) || !brk_q;
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    assign rd_data = bus.sel && !bus.we && (bus.addr == ADDR_DATA);
    assign rd_stat = bus.sel && !bus.we && (bus.addr == ADDR_STAT);
    assign wr_ctrl = bus.sel &&  bus.we && (bus.addr == ADDR_STAT);
    assign clr_err = wr_ctrl && bus.data_in[CTRL_CLR_BIT];
    assign flush   = wr_ctrl && bus.data_in[CTRL_FLUSH_BIT];
    assign unused_data_in = ^bus.data_in[DATA_W-1:2];

    xps2_rx_fifo #(
        .ADDR_W (FIFO_ADDR_W),
        .WIDTH  (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i ({brk_q, ext_q, shift_q}),
        .pop_i   (rd_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .ovr_o   (fifo_ovr)
    );

    always_comb begin
        data_word = '0;
        if (!fifo_empty) begin
            data_word[RD_VALID_BIT] = 1'b1;
            data_word[EVT_W-1:0]    = fifo_rdata;
        end
        stat_word = '0;
        stat_word[ST_COUNT_LSB +: FIFO_ADDR_W+1] = fifo_count;
        stat_word[ST_FULL_BIT]  = fifo_full;
        stat_word[ST_EMPTY_BIT] = fifo_empty;
        stat_word[ST_OVR_BIT]   = ovr_q;
        stat_word[ST_FERR_BIT]  = ferr_q;
        stat_word[ST_PERR_BIT]  = perr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            brk_q  <= brk_d;
            ext_q  <= ext_d;
            perr_q <= set_perr || (perr_q && !clr_err);
            ferr_q <= set_ferr || (ferr_q && !clr_err);
            ovr_q  <= fifo_ovr || (ovr_q  && !clr_err);
            irq_q  <= !fifo_empty;
            if (rd_data)      data_out_q <= data_word;
            else if (rd_stat) data_out_q <= stat_word;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.irq      = irq_q;

endmodule
